// File: rtl/des_rkey_seq_pkg.sv
// DES key-schedule constants shared by the sequential and combinational key generators.
// Tables are stored in DES bit order: entry 0 is table position 1, values are 1-based bit numbers.
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 56;
    localparam int RK_W   = 48;
    localparam int HALF_W = 28;

    localparam logic [0:55][5:0] PC1 = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [0:47][5:0] PC2 = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Entry i is the left-rotation applied before round i+1.
    localparam logic [0:15][1:0] SHIFT = {
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/des_rkey_seq_if.sv
// Request/round-key stream bundle between the key sequencer (slave) and its round core (master).
interface des_rkey_seq_if;
    logic                        start;
    logic                        decrypt;
    logic [des_pkg::KEY_W-1:0]   KEY;
    logic                        busy;
    logic                        rkey_valid;
    logic                        rkey_ready;
    logic [des_pkg::RK_W-1:0]    rkey;
    logic [3:0]                  rkey_idx;
    logic                        done;

    modport master (
        output start, decrypt, KEY, rkey_ready,
        input  busy, rkey_valid, rkey, rkey_idx, done
    );

    modport slave (
        input  start, decrypt, KEY, rkey_ready,
        output busy, rkey_valid, rkey, rkey_idx, done
    );
endinterface

// File: rtl/des_rkey_seq_pc2.sv
// DES PC-2 permutation, 56-bit {C,D} to 48-bit round key; purely combinational.
// Latency: zero; backpressure: none (no state).
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd_i,
    output logic [RK_W-1:0] k_o
);

    always_comb begin
        k_o = '0;
        for (int i = 0; i < RK_W; i++) begin
            k_o[6'(RK_W - 1 - i)] = cd_i[6'(CD_W - int'(PC2[6'(i)]))];
        end
    end

endmodule

// File: rtl/des_rkey_seq.sv
// Sequential DES key schedule: streams K1..K16 (encrypt) or K16..K1 (decrypt), one key per accept.
// Latency: first key valid the cycle after start; backpressure: key and C/D hold while rkey_ready is low.
module des_rkey_seq
    import des_pkg::*;
#(
    parameter bit ALLOW_ABORT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    des_rkey_seq_if.slave bus
);

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] o;
        o = '0;
        for (int i = 0; i < CD_W; i++) begin
            o[6'(CD_W - 1 - i)] = k[6'(KEY_W - int'(PC1[6'(i)]))];
        end
        return o;
    endfunction

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                dec_q, dec_d;
    logic                done_q, done_d;

    logic [CD_W-1:0]     key_pc1;
    logic                accept;
    logic                start_ok;
    logic [1:0]          shamt;
    logic [RK_W-1:0]     rkey_w;
    logic                unused_parity;

    assign key_pc1       = pc1(bus.KEY);
    assign unused_parity = ^{bus.KEY[56], bus.KEY[48], bus.KEY[40], bus.KEY[32],
                             bus.KEY[24], bus.KEY[16], bus.KEY[8],  bus.KEY[0]};

    assign accept   = (state_q == S_EMIT) && bus.rkey_ready;
    assign start_ok = bus.start && ((state_q == S_IDLE) || ALLOW_ABORT);

    // Decrypt walks back from K(16-cnt) to K(15-cnt): undo round (16-cnt)'s shift, table slot 15-cnt.
    assign shamt = dec_q ? SHIFT[~cnt_q] : SHIFT[cnt_q + 4'd1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        done_d  = 1'b0;

        if (start_ok) begin
            // C16/D16 equal C0/D0 (total rotation is 28), so decrypt loads PC-1 unrotated.
            state_d = S_EMIT;
            dec_d   = bus.decrypt;
            cnt_d   = '0;
            c_d     = bus.decrypt ? key_pc1[CD_W-1:HALF_W] : rotl28(key_pc1[CD_W-1:HALF_W], 2'd1);
            d_d     = bus.decrypt ? key_pc1[HALF_W-1:0]    : rotl28(key_pc1[HALF_W-1:0], 2'd1);
        end else if (accept) begin
            if (cnt_q == 4'd15) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
                c_d   = dec_q ? rotr28(c_q, shamt) : rotl28(c_q, shamt);
                d_d   = dec_q ? rotr28(d_q, shamt) : rotl28(d_q, shamt);
            end
        end
    end

    des_pc2 u_pc2 (
        .cd_i ({c_q, d_q}),
        .k_o  (rkey_w)
    );

    assign bus.rkey       = rkey_w;
    assign bus.rkey_valid = (state_q == S_EMIT);
    assign bus.busy       = (state_q == S_EMIT);
    assign bus.rkey_idx   = dec_q ? ~cnt_q : cnt_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_des_rkey_seq.sv
// Directed bench for des_rkey_seq: textbook key vectors, reversed order, throttling, abort, async reset.
module tb_des_rkey_seq;

    localparam logic [63:0] KA  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KB  = 64'h8FFB3DD99EEA2CC8;
    localparam logic [63:0] PAR = 64'h0101010101010101;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Round keys K1..K16 of KA, worked by hand.
    logic [47:0] KT [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    logic [47:0] kb_exp [16];

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    des_rkey_seq_if u_if  ();
    des_rkey_seq_if u_if0 ();

    des_rkey_seq #(.ALLOW_ABORT(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    des_rkey_seq #(.ALLOW_ABORT(1'b0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cumulative-rotation reference: K_r = PC2(rotl(C0, sum shifts), rotl(D0, sum shifts)).
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] o;
        int          sh;
        for (int i = 0; i < 28; i++) begin
            c[5'(27 - i)] = k[6'(64 - PC1_T[i])];
            d[5'(27 - i)] = k[6'(64 - PC1_T[28 + i])];
        end
        sh = 0;
        for (int j = 0; j < r; j++) sh = sh + SH_T[j];
        for (int j = 0; j < sh; j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) o[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [63:0] key, input logic dec);
        u_if.KEY     = key;
        u_if.decrypt = dec;
        u_if.start   = 1'b1;
        step();
        u_if.start   = 1'b0;
    endtask

    // Full stream with ready held high; returns in the done cycle.
    task automatic run_stream(input logic [63:0] key, input logic dec, input string tag);
        int idx;
        pulse_start(key, dec);
        chk({tag, "_done_lo"}, 64'(u_if.done), 64'd0);
        for (int k = 0; k < 16; k++) begin
            idx = dec ? 15 - k : k;
            chk($sformatf("%s_vld%0d", tag, k), 64'(u_if.rkey_valid), 64'd1);
            chk($sformatf("%s_idx%0d", tag, k), 64'(u_if.rkey_idx), 64'(idx));
            chk($sformatf("%s_key%0d", tag, k), 64'(u_if.rkey), 64'(KT[idx]));
            step();
        end
        chk({tag, "_done"}, 64'(u_if.done), 64'd1);
        chk({tag, "_vld_drop"}, 64'(u_if.rkey_valid), 64'd0);
        chk({tag, "_busy_drop"}, 64'(u_if.busy), 64'd0);
    endtask

    initial begin
        int accepts, dones, d0, d1;
        logic acc_now;

        for (int r = 1; r <= 16; r++) kb_exp[r - 1] = ref_key(KB, r);

        rst_n = 1'b0;
        u_if.start = 1'b0;  u_if.decrypt = 1'b0;  u_if.KEY = '0;  u_if.rkey_ready = 1'b1;
        u_if0.start = 1'b0; u_if0.decrypt = 1'b0; u_if0.KEY = '0; u_if0.rkey_ready = 1'b1;
        #12;
        chk("rst_busy",  64'(u_if.busy),       64'd0);
        chk("rst_vld",   64'(u_if.rkey_valid), 64'd0);
        chk("rst_rkey",  64'(u_if.rkey),       64'd0);
        chk("rst_idx",   64'(u_if.rkey_idx),   64'd0);
        chk("rst_done",  64'(u_if.done),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("idle_vld", 64'(u_if.rkey_valid), 64'd0);

        // Decrypt and parity streams start in the previous stream's done cycle.
        run_stream(KA, 1'b0, "enc");
        run_stream(KA, 1'b1, "dec");
        run_stream(KA ^ PAR, 1'b0, "par");
        step();
        chk("done_1cyc", 64'(u_if.done), 64'd0);

        // Random ready throttling.
        pulse_start(KB, 1'b0);
        accepts = 0;
        dones   = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (u_if.done) dones++;
            if (u_if.rkey_valid) begin
                if (accepts < 16) begin
                    chk($sformatf("thr_idx%0d", cyc), 64'(u_if.rkey_idx), 64'(accepts));
                    chk($sformatf("thr_key%0d", cyc), 64'(u_if.rkey), 64'(kb_exp[accepts]));
                end else begin
                    chk("thr_extra_vld", 64'(u_if.rkey_valid), 64'd0);
                end
            end
            u_if.rkey_ready = 1'($urandom_range(0, 1));
            acc_now = u_if.rkey_valid && u_if.rkey_ready;
            step();
            if (acc_now) accepts++;
        end
        u_if.rkey_ready = 1'b1;
        chk("thr_accepts", 64'(accepts), 64'd16);
        chk("thr_dones",   64'(dones),   64'd1);

        // Start while busy after 5 accepts: restarts on the abort build, ignored on the other.
        u_if0.KEY = KA; u_if0.decrypt = 1'b0; u_if0.start = 1'b1;
        pulse_start(KA, 1'b0);
        u_if0.start = 1'b0;
        d0 = 0;
        d1 = 0;
        for (int k = 0; k < 5; k++) step();
        chk("ab_pre_idx",  64'(u_if.rkey_idx),  64'd5);
        chk("ab_pre_idx0", 64'(u_if0.rkey_idx), 64'd5);
        u_if0.KEY = KB; u_if0.start = 1'b1;
        pulse_start(KB, 1'b0);
        u_if0.start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("ab1_idx%0d", k), 64'(u_if.rkey_idx), 64'(k));
            chk($sformatf("ab1_key%0d", k), 64'(u_if.rkey), 64'(kb_exp[k]));
            if (k < 10) begin
                chk($sformatf("ab0_idx%0d", k), 64'(u_if0.rkey_idx), 64'(6 + k));
                chk($sformatf("ab0_key%0d", k), 64'(u_if0.rkey), 64'(KT[6 + k]));
            end
            if (u_if.done)  d1++;
            if (u_if0.done) d0++;
            step();
        end
        if (u_if.done)  d1++;
        if (u_if0.done) d0++;
        step();
        if (u_if.done)  d1++;
        chk("ab1_dones", 64'(d1), 64'd1);
        chk("ab0_dones", 64'(d0), 64'd1);

        // Asynchronous reset between edges after 7 accepts.
        pulse_start(KA, 1'b0);
        for (int k = 0; k < 7; k++) step();
        chk("mid_idx", 64'(u_if.rkey_idx), 64'd7);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",  64'(u_if.rkey_valid), 64'd0);
        chk("arst_busy", 64'(u_if.busy),       64'd0);
        chk("arst_done", 64'(u_if.done),       64'd0);
        chk("arst_rkey", 64'(u_if.rkey),       64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        step();
        chk("post_vld",  64'(u_if.rkey_valid), 64'd0);
        chk("post_done", 64'(u_if.done),       64'd0);
        pulse_start(KA, 1'b0);
        chk("post_idx", 64'(u_if.rkey_idx), 64'd0);
        chk("post_k1",  64'(u_if.rkey),     64'(KT[0]));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/des_rkey_seq.md
Name: des_rkey_seq

Overview:
- Sequential DES key schedule. Streams the 16 48-bit round keys one per handshake, instead of presenting all 16 in parallel.
- Supports both orders:
  - Encrypt: K1..K16, using left rotations.
  - Decrypt: K16..K1, generated directly by right rotations with no storage of the full schedule.
- Feeds a single iterative DES round core.
- Shares the PC-1/PC-2/shift tables with the combinational key_gen.

Parameters:
- ALLOW_ABORT, 1, when 1 a start pulse while busy restarts the schedule; when 0 start is ignored while busy.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; samples KEY and decrypt.
- decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1.
- KEY  input  64  DES key; parity bits 8,16,...,64 are ignored.
- busy  output  1  high from the cycle after accepted start until the last key is accepted.
- rkey_valid  output  1  rkey/rkey_idx hold a valid round key.
- rkey_ready  input  1  consumer accepts the key on a cycle where rkey_valid && rkey_ready.
- rkey  output  48  current round key, PC-2 of the C/D registers.
- rkey_idx  output  4  DES round number minus 1 (0 = K1, 15 = K16) of the key on rkey.
- done  output  1  one-cycle pulse after the final key is accepted.

Behaviour:
- Reset values: C, D = 0; state = IDLE; round counter = 0; busy = 0; rkey_valid = 0; rkey = PC-2(0) = 0; rkey_idx = 0; done = 0. Reset mid-stream aborts with no done pulse.
- States: IDLE, EMIT.
- IDLE:
  - On start, register {C,D} ← PC-1(KEY), with the first shift pre-applied:
    - encrypt: rotl by 1;
    - decrypt: no rotation, because C16 = C0.
  - Latch the mode, clear the counter, go to EMIT.
- EMIT:
  - rkey_valid = 1, busy = 1.
  - rkey = PC-2(C,D), from registers only (no KEY path).
  - rkey_idx = counter (encrypt) or 15 − counter (decrypt).
- Accept (valid && ready) with counter < 15:
  - counter increments.
  - Encrypt: rotate C and D left by SHIFT[counter+1].
  - Decrypt: rotate C and D right by SHIFT[16−counter−1+1].
  - SHIFT (1-based, rounds 1..16) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Net decrypt right-rotation sequence between outputs: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Accept with counter == 15: go to IDLE, done = 1 for exactly one cycle, rkey_valid and busy drop in that same cycle.
- Backpressure: while rkey_ready = 0, rkey, rkey_idx and rkey_valid stay stable; no rotation occurs.
- Latency: start sampled at edge n → rkey_valid = 1 in cycle n+1. With ready held high, 16 keys arrive in 16 consecutive cycles and done is high in cycle n+17.
- start while in EMIT:
  - ALLOW_ABORT = 1: reload per the IDLE rule next cycle, counter = 0, no done for the aborted stream.
  - ALLOW_ABORT = 0: start is ignored.
- start in the same cycle as done (IDLE): accepted normally.
- Rotations are 28-bit circular, done independently on C and D. All arithmetic is on the 4-bit counter; no wrap beyond 15.

Decomposition:
- Package des_pkg holds:
  - PC1 (56 entries) and PC2 (48 entries) permutation tables;
  - SHIFT table (16 × 2-bit);
  - key width constants (64/56/48/28);
  - state enum.
- One sub-module: des_pc2, a combinational 56→48 permutation. It is reusable by key_gen.
- PC-1 and rotations stay inline.

Test Plan:
- Encrypt, ready = 1, KEY = 64'h133457799BBCDFF1 → rkey_idx 0..15 on consecutive cycles:
  - rkey K1 = 48'h1B02EFFC7072, K2 = 48'h79AED9DBC9E5, K16 = 48'hCB3D8B0E17F5;
  - done pulses once, cycle 17 after start.
- Decrypt, same KEY → first rkey = 48'hCB3D8B0E17F5 (idx 15), second = 48'hBF918D3D3F0A (idx 14), last = 48'h1B02EFFC7072 (idx 0).
  - Full sequence equals the encrypt sequence reversed, checked against a scoreboard.
- KEY = 64'h8FFB3DD99EEA2CC8, random ready throttling (~50%):
  - rkey/rkey_idx are stable whenever valid && !ready;
  - exactly 16 accepts, then one done;
  - keys match the combinational key_gen outputs r_key1..r_key16.
- Flip all 8 parity bits of KEY → identical key sequence.
- ALLOW_ABORT = 1: start with a new KEY after 5 accepts → next key is K1 of the new KEY, no done for the first stream.
  - ALLOW_ABORT = 0: the same start is ignored.
- Assert rst_n low mid-stream (after 7 accepts), asynchronously between edges → rkey_valid, busy and done go 0 immediately.
  - After release, the idle outputs hold until the next start, which then produces a correct K1.
